// File: rtl/division_controller.sv
`default_nettype none
// ============================================================================
// Module   : division_controller
// Purpose  : Execute-stage front end that sequences DIV/DIVU/REM/REMU through
//            an unsigned iterative divide core, with sign fix-up and stalls.
// Revision : 1.0
// ============================================================================
module division_controller #(
  parameter int VERI_GENISLIGI = 32,
  parameter int ZAMAN_ASIMI    = 40
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      gecerli_i,
  input  logic [1:0]                islem_i,
  input  logic [VERI_GENISLIGI-1:0] bolunen_i,
  input  logic [VERI_GENISLIGI-1:0] bolen_i,
  input  logic [4:0]                hedef_yazmac_i,
  input  logic                      iptal_i,
  output logic                      durdur_o,
  output logic [VERI_GENISLIGI-1:0] sonuc_o,
  output logic                      sonuc_gecerli_o,
  output logic [4:0]                hedef_yazmac_o,
  output logic                      hata_o,
  output logic                      cekirdek_basla_o,
  output logic [1:0]                cekirdek_islem_o,
  output logic [VERI_GENISLIGI-1:0] cekirdek_bolunen_o,
  output logic [VERI_GENISLIGI-1:0] cekirdek_bolen_o,
  input  logic [VERI_GENISLIGI-1:0] cekirdek_sonuc_i,
  input  logic                      cekirdek_bitti_i
);

  localparam int W  = VERI_GENISLIGI;
  localparam int CW = $clog2(ZAMAN_ASIMI + 1);

  localparam logic [2:0] C_BOSTA  = 3'd0;
  localparam logic [2:0] C_BASLAT = 3'd1;
  localparam logic [2:0] C_BEKLE  = 3'd2;
  localparam logic [2:0] C_DUZELT = 3'd3;
  localparam logic [2:0] C_SONUC  = 3'd4;

  localparam logic [W-1:0]  C_SIFIR     = '0;
  localparam logic [W-1:0]  C_HEPSI_BIR = '1;
  localparam logic [W-1:0]  C_EN_KUCUK  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] C_SON_SAYIM = CW'(ZAMAN_ASIMI - 1);
  localparam logic [CW-1:0] C_SAYAC_BIR = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    islem_q, islem_d;
  logic          isaret_a_q, isaret_a_d;
  logic          isaret_b_q, isaret_b_d;
  logic [W-1:0]  mag_a_q, mag_a_d;
  logic [W-1:0]  mag_b_q, mag_b_d;
  logic [4:0]    rd_q, rd_d;
  logic [W-1:0]  ham_q, ham_d;
  logic [W-1:0]  sonuc_q, sonuc_d;
  logic          mesgul_q, mesgul_d;
  logic [CW-1:0] sayac_q, sayac_d;
  logic          zaman_asimi_q, zaman_asimi_d;
  logic [1:0]    cekirdek_op_q, cekirdek_op_d;

  logic          w_kabul;
  logic          w_imzali;
  logic          w_isaret_a;
  logic          w_isaret_b;
  logic          w_sifir_bolen;
  logic          w_tasma;
  logic          w_ozel;
  logic [W-1:0]  w_ozel_sonuc;
  logic          w_bitti;
  logic          w_son_sayim;
  logic          w_negatif;
  logic [W-1:0]  w_duzeltilmis;

  // Operand classification for the instruction sitting in the execute register.
  always_comb begin
    w_kabul       = (state_q == C_BOSTA) && gecerli_i && !iptal_i && !mesgul_q;
    w_imzali      = !islem_i[0];
    w_isaret_a    = w_imzali && bolunen_i[W-1];
    w_isaret_b    = w_imzali && bolen_i[W-1];
    w_sifir_bolen = (bolen_i == C_SIFIR);
    w_tasma       = w_imzali && (bolunen_i == C_EN_KUCUK) && (bolen_i == C_HEPSI_BIR);
    w_ozel        = w_sifir_bolen || w_tasma;
    if (w_sifir_bolen) begin
      w_ozel_sonuc = islem_i[1] ? bolunen_i : C_HEPSI_BIR;
    end else begin
      w_ozel_sonuc = islem_i[1] ? C_SIFIR : C_EN_KUCUK;
    end
    w_bitti       = cekirdek_bitti_i && mesgul_q;
    w_son_sayim   = (sayac_q == C_SON_SAYIM);
    // Remainder follows the dividend sign; quotient follows the sign product.
    w_negatif     = islem_q[1] ? isaret_a_q : (isaret_a_q ^ isaret_b_q);
    w_duzeltilmis = w_negatif ? (C_SIFIR - ham_q) : ham_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= C_BOSTA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_BOSTA: begin
        if (w_kabul) begin
          state_d = w_ozel ? C_SONUC : C_BASLAT;
        end
      end
      C_BASLAT: state_d = iptal_i ? C_BOSTA : C_BEKLE;
      C_BEKLE: begin
        if (iptal_i) begin
          state_d = C_BOSTA;
        end else if (w_bitti) begin
          state_d = C_DUZELT;
        end else if (w_son_sayim) begin
          state_d = C_SONUC;
        end
      end
      C_DUZELT: state_d = iptal_i ? C_BOSTA : C_SONUC;
      C_SONUC:  state_d = C_BOSTA;
      default:  state_d = C_BOSTA;
    endcase
  end

  always_comb begin
    islem_d       = islem_q;
    isaret_a_d    = isaret_a_q;
    isaret_b_d    = isaret_b_q;
    mag_a_d       = mag_a_q;
    mag_b_d       = mag_b_q;
    rd_d          = rd_q;
    ham_d         = ham_q;
    sonuc_d       = sonuc_q;
    mesgul_d      = mesgul_q;
    sayac_d       = sayac_q;
    zaman_asimi_d = zaman_asimi_q;
    cekirdek_op_d = cekirdek_op_q;

    // Any done pulse from a started core frees it, even if its result is stale.
    if (w_bitti) begin
      mesgul_d = 1'b0;
    end

    case (state_q)
      C_BOSTA: begin
        if (w_kabul) begin
          islem_d       = islem_i;
          isaret_a_d    = w_isaret_a;
          isaret_b_d    = w_isaret_b;
          mag_a_d       = w_isaret_a ? (C_SIFIR - bolunen_i) : bolunen_i;
          mag_b_d       = w_isaret_b ? (C_SIFIR - bolen_i) : bolen_i;
          rd_d          = hedef_yazmac_i;
          cekirdek_op_d = {islem_i[1], 1'b1};
          if (w_ozel) begin
            sonuc_d       = w_ozel_sonuc;
            zaman_asimi_d = 1'b0;
          end
        end
      end
      C_BASLAT: begin
        mesgul_d = 1'b1;
        sayac_d  = '0;
      end
      C_BEKLE: begin
        sayac_d = sayac_q + C_SAYAC_BIR;
        if (!iptal_i) begin
          if (w_bitti) begin
            ham_d = cekirdek_sonuc_i;
          end else if (w_son_sayim) begin
            sonuc_d       = C_SIFIR;
            zaman_asimi_d = 1'b1;
          end
        end
      end
      C_DUZELT: begin
        if (!iptal_i) begin
          sonuc_d       = w_duzeltilmis;
          zaman_asimi_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      islem_q       <= '0;
      isaret_a_q    <= 1'b0;
      isaret_b_q    <= 1'b0;
      mag_a_q       <= '0;
      mag_b_q       <= '0;
      rd_q          <= '0;
      ham_q         <= '0;
      sonuc_q       <= '0;
      mesgul_q      <= 1'b0;
      sayac_q       <= '0;
      zaman_asimi_q <= 1'b0;
      cekirdek_op_q <= '0;
    end else begin
      islem_q       <= islem_d;
      isaret_a_q    <= isaret_a_d;
      isaret_b_q    <= isaret_b_d;
      mag_a_q       <= mag_a_d;
      mag_b_q       <= mag_b_d;
      rd_q          <= rd_d;
      ham_q         <= ham_d;
      sonuc_q       <= sonuc_d;
      mesgul_q      <= mesgul_d;
      sayac_q       <= sayac_d;
      zaman_asimi_q <= zaman_asimi_d;
      cekirdek_op_q <= cekirdek_op_d;
    end
  end

  always_comb begin
    durdur_o           = 1'b0;
    sonuc_gecerli_o    = 1'b0;
    hata_o             = 1'b0;
    cekirdek_basla_o   = 1'b0;
    sonuc_o            = sonuc_q;
    hedef_yazmac_o     = rd_q;
    cekirdek_islem_o   = cekirdek_op_q;
    cekirdek_bolunen_o = mag_a_q;
    cekirdek_bolen_o   = mag_b_q;
    case (state_q)
      C_BOSTA:  durdur_o = gecerli_i && !iptal_i;
      C_BASLAT: begin
        durdur_o         = 1'b1;
        cekirdek_basla_o = 1'b1;
      end
      C_BEKLE:  durdur_o = 1'b1;
      C_DUZELT: durdur_o = 1'b1;
      C_SONUC: begin
        sonuc_gecerli_o = !iptal_i;
        hata_o          = !iptal_i && zaman_asimi_q;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_division_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_division_controller
// Purpose  : Directed self-checking bench for division_controller.
// Revision : 1.0
// ============================================================================
module tb_division_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gecerli = 1'b0;
  logic [1:0]  islem = 2'b00;
  logic [31:0] bolunen = '0;
  logic [31:0] bolen = '0;
  logic [4:0]  hedef = '0;
  logic        iptal = 1'b0;
  logic [31:0] cek_sonuc = '0;
  logic        cek_bitti = 1'b0;

  logic        durdur;
  logic [31:0] sonuc;
  logic        sonuc_gecerli;
  logic [4:0]  hedef_o;
  logic        hata;
  logic        basla;
  logic [1:0]  cek_islem;
  logic [31:0] cek_a;
  logic [31:0] cek_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n_basla = 0;
  int n_strobe = 0;

  division_controller #(.VERI_GENISLIGI(32), .ZAMAN_ASIMI(40)) dut (
    .clk_i(clk), .rst_i(rst), .gecerli_i(gecerli), .islem_i(islem),
    .bolunen_i(bolunen), .bolen_i(bolen), .hedef_yazmac_i(hedef),
    .iptal_i(iptal), .durdur_o(durdur), .sonuc_o(sonuc),
    .sonuc_gecerli_o(sonuc_gecerli), .hedef_yazmac_o(hedef_o), .hata_o(hata),
    .cekirdek_basla_o(basla), .cekirdek_islem_o(cek_islem),
    .cekirdek_bolunen_o(cek_a), .cekirdek_bolen_o(cek_b),
    .cekirdek_sonuc_i(cek_sonuc), .cekirdek_bitti_i(cek_bitti)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (basla) n_basla <= n_basla + 1;
    if (sonuc_gecerli) n_strobe <= n_strobe + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":durdur"}, {31'd0, durdur}, 0);
    chk({tag, ":sonuc"}, sonuc, 0);
    chk({tag, ":gecerli"}, {31'd0, sonuc_gecerli}, 0);
    chk({tag, ":rd"}, {27'd0, hedef_o}, 0);
    chk({tag, ":hata"}, {31'd0, hata}, 0);
    chk({tag, ":basla"}, {31'd0, basla}, 0);
    chk({tag, ":cek_a"}, cek_a, 0);
    chk({tag, ":cek_b"}, cek_b, 0);
    chk({tag, ":cek_op"}, {30'd0, cek_islem}, 0);
  endtask

  // Normal op, accepted at once; core answers two cycles after BEKLE entry.
  task automatic run_normal(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] ma,
                            input logic [31:0] mb, input logic [1:0] cop,
                            input logic [31:0] cres, input logic [31:0] exp);
    int b0;
    b0 = n_basla;
    gecerli = 1'b1; islem = op; bolunen = a; bolen = b; hedef = rd;
    #1;
    chk({tag, ":stall_accept"}, {31'd0, durdur}, 1);
    chk({tag, ":no_basla_accept"}, {31'd0, basla}, 0);
    tick();
    chk({tag, ":basla"}, {31'd0, basla}, 1);
    chk({tag, ":cek_a"}, cek_a, ma);
    chk({tag, ":cek_b"}, cek_b, mb);
    chk({tag, ":cek_op"}, {30'd0, cek_islem}, {30'd0, cop});
    tick();
    chk({tag, ":basla_once"}, {31'd0, basla}, 0);
    chk({tag, ":stall_wait"}, {31'd0, durdur}, 1);
    tick();
    cek_bitti = 1'b1; cek_sonuc = cres;
    tick();
    cek_bitti = 1'b0; cek_sonuc = 32'h0;
    #1;
    chk({tag, ":stall_fix"}, {31'd0, durdur}, 1);
    chk({tag, ":no_early_strobe"}, {31'd0, sonuc_gecerli}, 0);
    tick();
    chk({tag, ":strobe"}, {31'd0, sonuc_gecerli}, 1);
    chk({tag, ":sonuc"}, sonuc, exp);
    chk({tag, ":rd"}, {27'd0, hedef_o}, {27'd0, rd});
    chk({tag, ":no_stall_res"}, {31'd0, durdur}, 0);
    chk({tag, ":no_hata"}, {31'd0, hata}, 0);
    gecerli = 1'b0;
    tick();
    chk({tag, ":strobe_single"}, {31'd0, sonuc_gecerli}, 0);
    chk({tag, ":sonuc_hold"}, sonuc, exp);
    chk({tag, ":one_basla"}, n_basla, b0 + 1);
  endtask

  // Special-case op resolved without the core, result one cycle after accept.
  task automatic run_special(input string tag, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [31:0] exp);
    int b0;
    b0 = n_basla;
    gecerli = 1'b1; islem = op; bolunen = a; bolen = b; hedef = rd;
    #1;
    chk({tag, ":stall_N"}, {31'd0, durdur}, 1);
    tick();
    chk({tag, ":strobe"}, {31'd0, sonuc_gecerli}, 1);
    chk({tag, ":sonuc"}, sonuc, exp);
    chk({tag, ":rd"}, {27'd0, hedef_o}, {27'd0, rd});
    chk({tag, ":no_stall_N1"}, {31'd0, durdur}, 0);
    chk({tag, ":no_basla"}, {31'd0, basla}, 0);
    gecerli = 1'b0;
    tick();
    chk({tag, ":strobe_single"}, {31'd0, sonuc_gecerli}, 0);
    chk({tag, ":no_stall_after"}, {31'd0, durdur}, 0);
    chk({tag, ":core_unused"}, n_basla, b0);
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Signed/unsigned normal operations through the core.
    run_normal("div_20_m3",  2'b00, 32'd20, 32'hFFFFFFFD, 5'd5, 32'd20, 32'd3, 2'b01, 32'd6, 32'hFFFFFFFA);
    run_normal("rem_20_m3",  2'b10, 32'd20, 32'hFFFFFFFD, 5'd6, 32'd20, 32'd3, 2'b11, 32'd2, 32'd2);
    run_normal("rem_m20_3",  2'b10, 32'hFFFFFFEC, 32'd3, 5'd7, 32'd20, 32'd3, 2'b11, 32'd2, 32'hFFFFFFFE);
    run_normal("divu_big_2", 2'b01, 32'hFFFFFFFE, 32'd2, 5'd8, 32'hFFFFFFFE, 32'd2, 2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF);

    // Divide-by-zero and signed overflow bypass the core.
    run_special("divu_7_0",  2'b01, 32'd7, 32'd0, 5'd10, 32'hFFFFFFFF);
    run_special("remu_7_0",  2'b11, 32'd7, 32'd0, 5'd11, 32'd7);
    run_special("div_m5_0",  2'b00, 32'hFFFFFFFB, 32'd0, 5'd12, 32'hFFFFFFFF);
    run_special("div_ovf",   2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000);
    run_special("rem_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000);

    // Flush during BEKLE, then a new op must wait for the stale done pulse.
    s0 = n_strobe;
    gecerli = 1'b1; islem = 2'b00; bolunen = 32'd100; bolen = 32'd7; hedef = 5'd9;
    tick();
    tick();
    tick();
    iptal = 1'b1; gecerli = 1'b0;
    tick();
    iptal = 1'b0;
    gecerli = 1'b1; hedef = 5'd12;
    #1;
    chk("flush:no_strobe", {31'd0, sonuc_gecerli}, 0);
    chk("flush:stall_busy", {31'd0, durdur}, 1);
    s0 = n_basla;
    tick();
    tick();
    tick();
    chk("flush:held_stall", {31'd0, durdur}, 1);
    chk("flush:no_new_basla", n_basla, s0);
    cek_bitti = 1'b1; cek_sonuc = 32'hDEADBEEF;
    tick();
    cek_bitti = 1'b0; cek_sonuc = 32'h0;
    #1;
    chk("flush:stale_ignored", {31'd0, sonuc_gecerli}, 0);
    chk("flush:still_no_basla", n_basla, s0);
    run_normal("div_100_7", 2'b00, 32'd100, 32'd7, 5'd12, 32'd100, 32'd7, 2'b01, 32'd14, 32'd14);

    // Core never answers: timeout exactly ZAMAN_ASIMI cycles after BEKLE entry.
    gecerli = 1'b1; islem = 2'b01; bolunen = 32'd50; bolen = 32'd5; hedef = 5'd3;
    tick();
    tick();
    for (int i = 1; i < 40; i++) begin
      tick();
      chk("tmo:no_early_result", {30'd0, hata, sonuc_gecerli}, 0);
    end
    tick();
    chk("tmo:hata", {31'd0, hata}, 1);
    chk("tmo:strobe", {31'd0, sonuc_gecerli}, 1);
    chk("tmo:sonuc_zero", sonuc, 0);
    chk("tmo:rd", {27'd0, hedef_o}, 3);
    gecerli = 1'b0;
    tick();
    chk("tmo:hata_single", {31'd0, hata}, 0);
    gecerli = 1'b1; islem = 2'b11; bolunen = 32'd9; bolen = 32'd4; hedef = 5'd4;
    s0 = n_basla;
    tick();
    tick();
    chk("tmo:next_stalls", {31'd0, durdur}, 1);
    chk("tmo:next_no_basla", n_basla, s0);
    cek_bitti = 1'b1; cek_sonuc = 32'h5;
    tick();
    cek_bitti = 1'b0; cek_sonuc = 32'h0;
    run_normal("remu_9_4", 2'b11, 32'd9, 32'd4, 5'd4, 32'd9, 32'd4, 2'b11, 32'd1, 32'd1);

    // Reset in BEKLE abandons the op silently.
    s0 = n_strobe;
    gecerli = 1'b1; islem = 2'b01; bolunen = 32'd30; bolen = 32'd4; hedef = 5'd7;
    tick();
    tick();
    tick();
    rst = 1'b1; gecerli = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset:no_strobe", n_strobe, s0);
    run_normal("remu_17_5", 2'b11, 32'd17, 32'd5, 5'd8, 32'd17, 32'd5, 2'b11, 32'd2, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
